sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
Successive-approximation search controller. It is the driving end of the team's combinational magnitude comparator. The block presents a registered trial value on the comparator's b operand and consumes its a_larger/equal results, deciding one bit per cycle MSB-first. It recovers the unknown SIZE-bit operand on comparator input a (threshold/level search) and returns it with a start/done handshake.

Parameters:
SIZE, 8, width of trial/result and of the partner comparator; must be >= 2.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new search; accepted only in IDLE
busy  output  1  high in SEARCH and DONE
trial  output  SIZE  registered trial value, drives comparator b
cmp_a_larger  input  1  comparator result: unknown a > trial
cmp_equal  input  1  comparator result: unknown a == trial
done  output  1  one-cycle pulse, result valid
result  output  SIZE  found value, held until the next accepted start
steps  output  $clog2(SIZE+1)  SEARCH cycles used by the last search

Behaviour:
- Reset is asynchronous and active-high. Reset values: state=IDLE, trial=0, result=0, steps=0, done=0, busy=0. Reset mid-search aborts with no done pulse.
- The comparator path is combinational. cmp_* are sampled in the same cycle trial is presented.
- States and transitions:
  - IDLE: start=1 -> trial<=1<<(SIZE-1), bit index k<=SIZE-1, step count<=0, go to SEARCH. start=0 -> stay.
  - SEARCH, bit k:
    - keep = cmp_a_larger | cmp_equal.
    - next = keep ? trial : trial & ~(1<<k).
    - If k>0: trial<=next | (1<<(k-1)), k<=k-1.
    - If k==0: result<=next, trial<=next, go to DONE.
    - Step count increments each SEARCH cycle.
  - DONE: done=1 for exactly this cycle, steps<=count, then go to IDLE.
- Latency: start accepted at cycle 0, SEARCH spans cycles 1..SIZE, done is high in cycle SIZE+1. The next start is accepted in cycle SIZE+2 at the earliest.
- start while busy (SEARCH or DONE) is ignored, not queued.
- result and steps hold their values until they are overwritten at the next DONE. trial holds the final value while in IDLE.
- Boundaries:
  - unknown=0: every bit is cleared, result=0.
  - unknown=2^SIZE-1: every bit is kept.
  - cmp_a_larger and cmp_equal both high (illegal from the comparator): treated as keep.
- All arithmetic is unsigned. steps saturates at SIZE (this cannot be exceeded).

Optional Feature:
SAR_SEARCH_EARLY_EXIT_EN
- Defined: in SEARCH, cmp_equal=1 ends the search at once: result<=trial (remaining lower bits stay 0), steps<=count including this cycle, go to DONE. Latency becomes variable: done appears in cycle (steps+1).
- Undefined: cmp_equal is used only through keep, and every search takes exactly SIZE SEARCH cycles. Results are identical in both builds; only the timing and steps differ.

Decomposition:
- Shared package sar_pkg holds:
  - state enum sar_state_t {SAR_IDLE, SAR_SEARCH, SAR_DONE};
  - localparam helper for the steps width ($clog2(SIZE+1)).
- No sub-module inside the block. The one-hot bit mask is a small shift register within sar_search.
- The bench instantiates the team's magnitude comparator (SIZE matching) with a=unknown and b=trial, and feeds its a_larger/equal back into the block.

Test Plan:
1. Reset mid-search: SIZE=8, unknown=0xA5, assert rst during the 4th SEARCH cycle -> immediately busy=0, trial=0, result=0, no done pulse. A later start yields result=0xA5.
2. Nominal: SIZE=8, unknown=0xA5, start for 1 cycle -> trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; done in cycle 9; result=0xA5; steps=8 (feature off).
3. Extremes: unknown=0x00 -> result=0x00; unknown=0xFF -> result=0xFF. Both steps=8, done in cycle 9.
4. Start while busy: second start in cycles 3 and 9 -> ignored. A single done pulse, and the next search starts only after IDLE is reached.
5. Early exit (macro defined): unknown=0x80 -> cmp_equal in the first SEARCH cycle, done in cycle 2, result=0x80, steps=1. unknown=0x01 -> steps=8.
6. Back-to-back: start held high continuously, unknown changes 0x3C -> 0xC3 between searches -> results 0x3C then 0xC3, with starts accepted at cycles 0 and 10.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller.
// Holds the FSM state encoding and the width helper for the steps counter.
package sar_pkg;

   typedef enum logic [1:0] {
      SAR_IDLE   = 2'd0,
      SAR_SEARCH = 2'd1,
      SAR_DONE   = 2'd2
   } sar_state_t;

   localparam int SAR_SIZE_DEF    = 8;
   localparam int SAR_STEPS_W_DEF = $clog2(SAR_SIZE_DEF + 1);

   // The steps counter must hold the value SIZE itself.
   function automatic int sar_steps_w(input int size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/sar_search_if.sv
// Handshake and comparator bundle between sar_search and its user.
// The master side drives start and the comparator results; the slave is the search block.
interface sar_search_if #(
   parameter int SIZE = 8
);
   localparam int STEPS_W = sar_pkg::sar_steps_w(SIZE);

   logic               start;
   logic               busy;
   logic [SIZE-1:0]    trial;
   logic               cmp_a_larger;
   logic               cmp_equal;
   logic               done;
   logic [SIZE-1:0]    result;
   logic [STEPS_W-1:0] steps;

   modport master (
      output start, cmp_a_larger, cmp_equal,
      input  busy, trial, done, result, steps
   );

   modport slave (
      input  start, cmp_a_larger, cmp_equal,
      output busy, trial, done, result, steps
   );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: drives a trial value into a magnitude comparator
// and settles one bit per cycle MSB-first. Optional macro SAR_SEARCH_EARLY_EXIT_EN ends on equality.
module sar_search
   import sar_pkg::*;
#(
   parameter int SIZE = 8
) (
   input logic        clk,
   input logic        rst,
   sar_search_if.slave bus
);

   localparam int                  STEPS_W   = sar_steps_w(SIZE);
   localparam logic [SIZE-1:0]     MSB_ONE   = {1'b1, {(SIZE-1){1'b0}}};
   localparam logic [STEPS_W-1:0]  COUNT_MAX = STEPS_W'(SIZE);

   sar_state_t         r_state;
   sar_state_t         w_next_state;
   logic [SIZE-1:0]    r_trial;
   logic [SIZE-1:0]    r_mask;
   logic [SIZE-1:0]    r_result;
   logic [STEPS_W-1:0] r_count;
   logic [STEPS_W-1:0] r_steps;
   logic               r_done;
   logic               r_busy;

   logic [SIZE-1:0]    w_trial_d;
   logic [SIZE-1:0]    w_mask_d;
   logic [SIZE-1:0]    w_result_d;
   logic [STEPS_W-1:0] w_count_d;
   logic [STEPS_W-1:0] w_steps_d;
   logic [SIZE-1:0]    w_next_bits;
   logic               w_keep;
   logic               w_last;
   logic               w_early;

   // Both-high from the comparator is illegal but resolves to keep.
   assign w_keep      = bus.cmp_a_larger | bus.cmp_equal;
   assign w_next_bits = w_keep ? r_trial : (r_trial & ~r_mask);
   assign w_last      = r_mask[0];

`ifdef SAR_SEARCH_EARLY_EXIT_EN
   assign w_early = bus.cmp_equal;
`else
   assign w_early = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= SAR_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         SAR_IDLE: begin
            if (bus.start) w_next_state = SAR_SEARCH;
            else           w_next_state = SAR_IDLE;
         end
         SAR_SEARCH: begin
            if (w_last || w_early) w_next_state = SAR_DONE;
            else                   w_next_state = SAR_SEARCH;
         end
         SAR_DONE: w_next_state = SAR_IDLE;
         default:  w_next_state = SAR_IDLE;
      endcase
   end

   // Datapath next values; the mask is a one-hot pointer to the bit under test.
   always_comb begin
      w_trial_d  = r_trial;
      w_mask_d   = r_mask;
      w_result_d = r_result;
      w_count_d  = r_count;
      w_steps_d  = r_steps;
      case (r_state)
         SAR_IDLE: begin
            if (bus.start) begin
               w_trial_d = MSB_ONE;
               w_mask_d  = MSB_ONE;
               w_count_d = '0;
            end else begin
               w_trial_d = r_trial;
            end
         end
         SAR_SEARCH: begin
            w_count_d = (r_count == COUNT_MAX) ? COUNT_MAX : r_count + STEPS_W'(1);
            if (w_early) begin
               w_result_d = r_trial;
               w_trial_d  = r_trial;
            end else if (w_last) begin
               w_result_d = w_next_bits;
               w_trial_d  = w_next_bits;
            end else begin
               w_trial_d = w_next_bits | (r_mask >> 1);
               w_mask_d  = r_mask >> 1;
            end
         end
         SAR_DONE: w_steps_d = r_count;
         default:  w_trial_d = r_trial;
      endcase
   end

   // Datapath and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_trial  <= '0;
         r_mask   <= '0;
         r_result <= '0;
         r_count  <= '0;
         r_steps  <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_trial  <= w_trial_d;
         r_mask   <= w_mask_d;
         r_result <= w_result_d;
         r_count  <= w_count_d;
         r_steps  <= w_steps_d;
         r_done   <= (w_next_state == SAR_DONE);
         r_busy   <= (w_next_state != SAR_IDLE);
      end
   end

   assign bus.busy   = r_busy;
   assign bus.trial  = r_trial;
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.steps  = r_steps;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: ideal comparator in the loop, randomized unknowns,
// reference trial sequence and step counts derived arithmetically from the unknown value.
module tb_sar_search;

   localparam int SIZE = 8;
   localparam int SW   = $clog2(SIZE + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic [SIZE-1:0] unknown;
   logic            force_both;
   int              checks = 0;
   int              errors = 0;

   sar_search_if #(.SIZE(SIZE)) u_if ();
   sar_search #(.SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(u_if.slave));

   always #5 clk = ~clk;

   // Ideal magnitude comparator, optionally forced into the illegal both-high state.
   assign u_if.cmp_a_larger = force_both | (unknown > u_if.trial);
   assign u_if.cmp_equal    = force_both | (unknown == u_if.trial);

   // Trial in step i: bits of u above position p, plus bit p set, where p = SIZE-1-i.
   function automatic logic [SIZE-1:0] model_trial(input logic [SIZE-1:0] u, input int i);
      int p;
      int hm;
      p  = SIZE - 1 - i;
      hm = ~((1 << (p + 1)) - 1);
      return SIZE'((int'(u) & hm) | (1 << p));
   endfunction

   function automatic int model_steps(input logic [SIZE-1:0] u);
`ifdef SAR_SEARCH_EARLY_EXIT_EN
      for (int b = 0; b < SIZE; b++) begin
         if (u[b]) return SIZE - b;
      end
      return SIZE;
`else
      return SIZE;
`endif
   endfunction

   // Starts from mid-cycle in IDLE, ends at the falling edge of the following IDLE cycle.
   task automatic test_search(input logic [SIZE-1:0] u, input string tag);
      int done_cyc;
      int exp_st;
      exp_st   = model_steps(u);
      done_cyc = -1;
      unknown  = u;
      u_if.start = 1'b1;
      @(posedge clk); #1;
      u_if.start = 1'b0;
      for (int c = 1; c <= SIZE + 1; c++) begin
         @(negedge clk);
         if (u_if.done === 1'b1) begin
            done_cyc = c;
            break;
         end
         if (c <= SIZE) begin
            checks++;
            if (u_if.trial !== model_trial(u, c - 1) || u_if.busy !== 1'b1) begin
               errors++;
               $display("FAIL %s trial c%0d: got %h busy %b, expected %h busy 1",
                        tag, c, u_if.trial, u_if.busy, model_trial(u, c - 1));
            end
         end
         @(posedge clk); #1;
      end
      checks++;
      if (done_cyc != exp_st + 1) begin
         errors++;
         $display("FAIL %s done_cycle: got %0d, expected %0d", tag, done_cyc, exp_st + 1);
      end
      if (done_cyc < 0) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         return;
      end
      checks++;
      if (u_if.result !== u) begin
         errors++;
         $display("FAIL %s result: got %h, expected %h", tag, u_if.result, u);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (u_if.done !== 1'b0 || u_if.busy !== 1'b0 || u_if.steps !== SW'(exp_st)
          || u_if.trial !== u || u_if.result !== u) begin
         errors++;
         $display("FAIL %s idle: got done %b busy %b steps %0d trial %h result %h, expected 0 0 %0d %h %h",
                  tag, u_if.done, u_if.busy, u_if.steps, u_if.trial, u_if.result, exp_st, u, u);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; u_if.start = 1'b0; unknown = '0; force_both = 1'b0;
      #12;
      checks++;
      if ({u_if.busy, u_if.done, u_if.trial, u_if.result, u_if.steps} !== '0) begin
         errors++;
         $display("FAIL reset: got busy %b done %b trial %h result %h steps %0d, expected all 0",
                  u_if.busy, u_if.done, u_if.trial, u_if.result, u_if.steps);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      int ndone;
      ndone   = 0;
      unknown = 8'hA5;
      u_if.start = 1'b1;
      @(posedge clk); #1;
      u_if.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (u_if.busy !== 1'b0 || u_if.trial !== '0 || u_if.result !== '0 || u_if.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got busy %b trial %h result %h done %b, expected 0 00 00 0",
                  u_if.busy, u_if.trial, u_if.result, u_if.done);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (u_if.done === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL reset_mid_no_done: got %0d done pulses, expected 0", ndone);
      end
      test_search(8'hA5, "after_reset");
   endtask

   task automatic test_busy_start();
      logic [SIZE-1:0] u;
      int ndone;
      int dcyc;
      u = 8'h5B; ndone = 0; dcyc = -1;
      unknown = u;
      u_if.start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 20; c++) begin
         u_if.start = (c == 3 || c == 9);
         @(negedge clk);
         if (u_if.done === 1'b1) begin
            ndone++;
            dcyc = c;
         end
         @(posedge clk); #1;
      end
      u_if.start = 1'b0;
      @(negedge clk);
      checks++;
      if (ndone != 1 || dcyc != model_steps(u) + 1 || u_if.busy !== 1'b0 || u_if.result !== u) begin
         errors++;
         $display("FAIL busy_start: got %0d pulses at c%0d busy %b result %h, expected 1 at c%0d busy 0 result %h",
                  ndone, dcyc, u_if.busy, u_if.result, model_steps(u) + 1, u);
      end
   endtask

   task automatic test_illegal();
      logic [SIZE-1:0] exp_res;
      int exp_st;
      int dcyc;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
      exp_res = 8'h80; exp_st = 1;
`else
      exp_res = 8'hFF; exp_st = SIZE;
`endif
      dcyc = -1;
      force_both = 1'b1;
      u_if.start = 1'b1;
      @(posedge clk); #1;
      u_if.start = 1'b0;
      for (int c = 1; c <= SIZE + 2; c++) begin
         @(negedge clk);
         if (u_if.done === 1'b1) begin
            dcyc = c;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (dcyc != exp_st + 1 || u_if.result !== exp_res) begin
         errors++;
         $display("FAIL both_high: got done c%0d result %h, expected c%0d result %h",
                  dcyc, u_if.result, exp_st + 1, exp_res);
      end
      force_both = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int nd;
      int dc[2];
      logic [SIZE-1:0] res[2];
      int s1;
      int s2;
      s1 = model_steps(8'h3C); s2 = model_steps(8'hC3);
      nd = 0; dc[0] = -1; dc[1] = -1; res[0] = '0; res[1] = '0;
      unknown = 8'h3C;
      u_if.start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (u_if.done === 1'b1) begin
            dc[nd]  = c;
            res[nd] = u_if.result;
            nd++;
            unknown = 8'hC3;
            if (nd == 2) begin
               u_if.start = 1'b0;
               break;
            end
         end
         @(posedge clk); #1;
      end
      u_if.start = 1'b0;
      checks++;
      if (dc[0] != s1 + 1 || res[0] !== 8'h3C) begin
         errors++;
         $display("FAIL b2b_first: got done c%0d result %h, expected c%0d result 3c", dc[0], res[0], s1 + 1);
      end
      checks++;
      if (dc[1] != s1 + s2 + 3 || res[1] !== 8'hC3) begin
         errors++;
         $display("FAIL b2b_second: got done c%0d result %h, expected c%0d result c3",
                  dc[1], res[1], s1 + s2 + 3);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (u_if.busy !== 1'b0 || u_if.steps !== SW'(s2)) begin
         errors++;
         $display("FAIL b2b_idle: got busy %b steps %0d, expected 0 %0d", u_if.busy, u_if.steps, s2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_search(8'hA5, "nominal");
      test_reset_mid();
      test_search(8'h00, "zero");
      test_search(8'hFF, "all_ones");
      test_busy_start();
      test_search(8'h80, "early_msb");
      test_search(8'h01, "early_lsb");
      test_illegal();
      test_back_to_back();
      for (int n = 0; n < 20; n++) begin
         test_search(SIZE'($urandom_range(0, 255)), "random");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
